tinyflash_sd_dac: RTL

TINYFLASH_SD_DAC -- requirements
Module: tinyflash_sd_dac

---
 rtl/tinyflash_sd_dac.sv | 98 +++++++++
 1 files changed

// File: rtl/tinyflash_sd_dac.sv
// tinyflash_sd_dac: sample FIFO + rate counter feeding a first-order
// delta-sigma modulator that drives a 1-bit DAC pin.
// Optional LFSR dither on the modulator carry-in: define TINYFLASH_SD_DITHER_EN.
module tinyflash_sd_dac #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [7:0]       rate_div,
  output logic             dac_bit,
  output logic             sample_tick,
  output logic [2:0]       fifo_level,
  output logic             underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]       cnt;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   sum;
  logic             tick, push, pop, cin;

  // Tick when the count reaches (or has been left above) the programmed period.
  assign tick        = rst_n && ena && (cnt >= rate_div);
  assign sample_tick = tick;
  assign din_ready   = ena && (fifo_level < 3'(DEPTH));
  assign push        = din_valid && din_ready;
  assign pop         = tick && (fifo_level != 3'd0);

  // Modulator adder: one carry out of the WIDTH-bit accumulator per output one.
  assign sum = {1'b0, acc} + {1'b0, hold} + {{WIDTH{1'b0}}, cin};

`ifdef TINYFLASH_SD_DITHER_EN
  logic [7:0] lfsr;

  // 8-bit Fibonacci LFSR, taps 8,6,5,4; advances every enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   lfsr <= 8'h01;
    else if (ena) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign cin = lfsr[0];
`else
  assign cin = 1'b0;
`endif

  // Sample-rate counter: wraps to 0 on the tick cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else if (ena)  cnt <= cnt + 8'd1;
  end

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // FIFO pointers, level, hold register and sticky underflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      hold       <= '0;
      underflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
        hold   <= mem[rd_ptr];
      end
      if (tick && fifo_level == 3'd0) underflow <= 1'b1;
      if (push && !pop)      fifo_level <= fifo_level + 3'd1;
      else if (pop && !push) fifo_level <= fifo_level - 3'd1;
    end
  end

  // Delta-sigma accumulator and registered output bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      dac_bit <= 1'b0;
    end else if (ena) begin
      acc     <= sum[WIDTH-1:0];
      dac_bit <= sum[WIDTH];
    end
  end

endmodule
